spec_tlb_gen2: RTL and testbench
================================

Name: spec_tlb_gen2

Overview:
- Parametrised second-generation speculative TLB. Translates virtual to physical addresses through a fully associative table that holds mixed small-page and large-page entries.
- Speculative requests look up and fill at large-page granularity. Normal requests hit on either entry size.
- Misses go to a small-page or large-page table walker over a request/done handshake.
- Sits between the address-generation client and the two page-table modules. Adds a ready/valid request port, flush, round-robin replacement and hit/miss counters.

Parameters:
- VA_W, 9, virtual address width.
- PA_W, 9, physical address width.
- SMALL_OFF, 3, small-page offset bits (8-byte pages).
- LARGE_OFF, 5, large-page offset bits (32-byte pages); LARGE_OFF > SMALL_OFF.
- ENTRIES, 4, TLB entries (power of 2, at least 2).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  translation request valid.
- REQ_READY  out  1  block can accept a request.
- REQ_SPEC  in  1  speculative (large-page) request; sampled on accept.
- REQ_VADDR  in  VA_W  virtual address; sampled on accept.
- RSP_VALID  out  1  one-cycle pulse; response fields valid.
- RSP_PADDR  out  PA_W  translated physical address.
- RSP_HIT  out  1  1 = served from TLB, 0 = served by walk.
- RSP_SPEC_HIT  out  1  1 = hit on a large-page entry.
- FLUSH  in  1  invalidate all entries.
- WALK_S_RQST  out  1  small-page walk request (level).
- WALK_S_VPN  out  VA_W-SMALL_OFF  small VPN to walk.
- WALK_S_DONE  in  1  small walk complete.
- WALK_S_PPN  in  PA_W-SMALL_OFF  returned small PPN.
- WALK_L_RQST  out  1  large-page walk request (level).
- WALK_L_VPN  out  VA_W-LARGE_OFF  large VPN to walk.
- WALK_L_DONE  in  1  large walk complete.
- WALK_L_PPN  in  PA_W-LARGE_OFF  returned large PPN.
- HIT_CNT  out  CNT_W  saturating count of hits.
- MISS_CNT  out  CNT_W  saturating count of misses.

Behaviour:
Reset state (rst high, asynchronous):
- All entry valid bits = 0; round-robin pointer = 0; state = IDLE.
- REQ_READY = 1; RSP_VALID = RSP_HIT = RSP_SPEC_HIT = 0; RSP_PADDR = 0.
- WALK_*_RQST = 0; WALK_*_VPN = 0; HIT_CNT = MISS_CNT = 0.

Entry format: valid, large flag, VPN field (VA_W-SMALL_OFF bits), PPN field (PA_W-SMALL_OFF bits). Large entries store their VPN/PPN left-aligned in these fields, with the low LARGE_OFF-SMALL_OFF bits zero.

State machine:
- IDLE: REQ_READY = 1. On REQ_VALID, latch VADDR and SPEC, then go to LOOKUP.
- LOOKUP (1 cycle): compare all entries in parallel.
  - A large entry matches if VADDR[VA_W-1:LARGE_OFF] equals its large VPN.
  - A small entry matches only on a non-spec request, if VADDR[VA_W-1:SMALL_OFF] equals its VPN.
  - Hit -> RESP. A spec miss -> WALK_L. A non-spec miss -> WALK_S.
  - Multiple matches: the lowest index wins.
- WALK_S / WALK_L:
  - Hold RQST = 1 and VPN stable until the matching DONE is sampled high.
  - On DONE, capture the PPN and fill an entry, then go to RESP with RSP_HIT = 0. The RQST for that walk is 0 in RESP.
  - DONE on the other walker is ignored.
- RESP: RSP_VALID = 1 for exactly one cycle, REQ_READY = 0; next state IDLE.

Physical address:
- Small: {PPN, VADDR[SMALL_OFF-1:0]}.
- Large: {large PPN, VADDR[LARGE_OFF-1:0]}.

Latency:
- Hit: RSP_VALID two cycles after the accept edge.
- Miss: RSP_VALID one cycle after the DONE edge.
- Only one request is in flight at a time.

Fill victim:
- The lowest-index invalid entry if one exists.
- Otherwise the entry at the round-robin pointer, after which the pointer increments modulo ENTRIES.

Counters:
- Increment once per response: HIT_CNT if RSP_HIT, else MISS_CNT.
- Both saturate at all-ones.

FLUSH:
- Clears all valid bits and the pointer in any state. It does not change the state or an in-progress walk.
- FLUSH in the same cycle as a fill: the flush wins and no entry is written, but the response is still delivered.
- FLUSH in LOOKUP: the lookup uses pre-flush contents.

rst mid-walk: RQST drops asynchronously and the pending response is discarded. Walkers must tolerate an abandoned request.

Test Plan:
- Default parameters, after reset, non-spec VADDR = 0x1AB -> WALK_S_RQST = 1, WALK_S_VPN = 0x35. Drive DONE with PPN = 0x12 -> RSP_PADDR = 0x093, RSP_HIT = 0, MISS_CNT = 1.
- Repeat VADDR 0x1AB -> RSP_VALID two cycles after accept, RSP_PADDR = 0x093, RSP_HIT = 1, RSP_SPEC_HIT = 0, no walk, HIT_CNT = 1.
- Spec VADDR = 0x0E7 -> WALK_L_VPN = 0x7. PPN = 0x9 -> RSP_PADDR = 0x127. Then non-spec VADDR = 0x0F0 -> RSP_HIT = 1, RSP_SPEC_HIT = 1, RSP_PADDR = 0x130.
- Spec VADDR = 0x1AB with only small entry 0x35 present -> WALK_L_RQST = 1 with VPN 0xD (small entries never match spec requests).
- Fill five distinct small VPNs 0x00..0x04 -> the fifth overwrites entry 0. VADDR 0x000 then misses, and a later fill overwrites entry 1.
- Assert FLUSH during WALK_S, then DONE -> response delivered and all entries remain invalid. Assert rst during WALK_L -> WALK_L_RQST = 0 immediately, no RSP_VALID, REQ_READY = 1.

Source files
------------

// File: rtl/spec_tlb_gen2.sv
// spec_tlb_gen2: fully associative speculative TLB with mixed small/large
// page entries, small/large table-walk ports, flush, round-robin
// replacement and saturating hit/miss counters.
module spec_tlb_gen2 #(
  parameter int VA_W      = 9,
  parameter int PA_W      = 9,
  parameter int SMALL_OFF = 3,
  parameter int LARGE_OFF = 5,
  parameter int ENTRIES   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic                      REQ_SPEC,
  input  logic [VA_W-1:0]           REQ_VADDR,
  output logic                      RSP_VALID,
  output logic [PA_W-1:0]           RSP_PADDR,
  output logic                      RSP_HIT,
  output logic                      RSP_SPEC_HIT,
  input  logic                      FLUSH,
  output logic                      WALK_S_RQST,
  output logic [VA_W-SMALL_OFF-1:0] WALK_S_VPN,
  input  logic                      WALK_S_DONE,
  input  logic [PA_W-SMALL_OFF-1:0] WALK_S_PPN,
  output logic                      WALK_L_RQST,
  output logic [VA_W-LARGE_OFF-1:0] WALK_L_VPN,
  input  logic                      WALK_L_DONE,
  input  logic [PA_W-LARGE_OFF-1:0] WALK_L_PPN,
  output logic [CNT_W-1:0]          HIT_CNT,
  output logic [CNT_W-1:0]          MISS_CNT
);

  localparam int VPN_W = VA_W - SMALL_OFF;
  localparam int PPN_W = PA_W - SMALL_OFF;
  localparam int LD    = LARGE_OFF - SMALL_OFF;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WALK_S, S_WALK_L, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [VA_W-1:0]        vaddr_q, vaddr_d;
  logic                   spec_q, spec_d;
  logic [ENTRIES-1:0]     valid_q, valid_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [PA_W-1:0]        rsp_paddr_q, rsp_paddr_d;
  logic                   rsp_hit_q, rsp_hit_d;
  logic                   rsp_spec_hit_q, rsp_spec_hit_d;
  logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;

  // Entry payload: only meaningful where the valid bit is set, so not reset.
  logic                   large_q [ENTRIES];
  logic [VPN_W-1:0]       vpn_q   [ENTRIES];
  logic [PPN_W-1:0]       ppn_q   [ENTRIES];

  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic                   hit_large;
  logic                   has_inv;
  logic [IDX_W-1:0]       inv_idx;
  logic [IDX_W-1:0]       victim;
  logic                   fill_en;
  logic                   fill_large;
  logic [VPN_W-1:0]       fill_vpn;
  logic [PPN_W-1:0]       fill_ppn;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Parallel tag compare and free-slot search; descending loops leave the lowest index.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    hit_large = 1'b0;
    has_inv   = 1'b0;
    inv_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] &&
          (large_q[i] ? (vpn_q[i][VPN_W-1:LD] == vaddr_q[VA_W-1:LARGE_OFF])
                      : (!spec_q && (vpn_q[i] == vaddr_q[VA_W-1:SMALL_OFF])))) begin
        hit       = 1'b1;
        hit_idx   = i[IDX_W-1:0];
        hit_large = large_q[i];
      end
      if (!valid_q[i]) begin
        has_inv = 1'b1;
        inv_idx = i[IDX_W-1:0];
      end
    end
    victim = has_inv ? inv_idx : ptr_q;
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      vaddr_q        <= '0;
      spec_q         <= 1'b0;
      valid_q        <= '0;
      ptr_q          <= '0;
      rsp_paddr_q    <= '0;
      rsp_hit_q      <= 1'b0;
      rsp_spec_hit_q <= 1'b0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      vaddr_q        <= vaddr_d;
      spec_q         <= spec_d;
      valid_q        <= valid_d;
      ptr_q          <= ptr_d;
      rsp_paddr_q    <= rsp_paddr_d;
      rsp_hit_q      <= rsp_hit_d;
      rsp_spec_hit_q <= rsp_spec_hit_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  // Entry payload write on an unflushed fill.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      large_q[victim] <= fill_large;
      vpn_q[victim]   <= fill_vpn;
      ppn_q[victim]   <= fill_ppn;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (REQ_VALID) state_d = S_LOOKUP;
      S_LOOKUP: state_d = hit ? S_RESP : (spec_q ? S_WALK_L : S_WALK_S);
      S_WALK_S: if (WALK_S_DONE) state_d = S_RESP;
      S_WALK_L: if (WALK_L_DONE) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: request capture, response build, fill, flush and counters.
  always_comb begin
    vaddr_d        = vaddr_q;
    spec_d         = spec_q;
    rsp_paddr_d    = rsp_paddr_q;
    rsp_hit_d      = rsp_hit_q;
    rsp_spec_hit_d = rsp_spec_hit_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    fill_en        = 1'b0;
    fill_large     = 1'b0;
    fill_vpn       = vaddr_q[VA_W-1:SMALL_OFF];
    fill_ppn       = WALK_S_PPN;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          vaddr_d = REQ_VADDR;
          spec_d  = REQ_SPEC;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          rsp_paddr_d    = hit_large
                           ? {ppn_q[hit_idx][PPN_W-1:LD], vaddr_q[LARGE_OFF-1:0]}
                           : {ppn_q[hit_idx], vaddr_q[SMALL_OFF-1:0]};
          rsp_hit_d      = 1'b1;
          rsp_spec_hit_d = hit_large;
          hit_cnt_d      = sat_inc(hit_cnt_q);
        end
      end
      S_WALK_S: begin
        if (WALK_S_DONE) begin
          rsp_paddr_d    = {WALK_S_PPN, vaddr_q[SMALL_OFF-1:0]};
          rsp_hit_d      = 1'b0;
          rsp_spec_hit_d = 1'b0;
          miss_cnt_d     = sat_inc(miss_cnt_q);
          fill_en        = !FLUSH;
        end
      end
      S_WALK_L: begin
        if (WALK_L_DONE) begin
          rsp_paddr_d    = {WALK_L_PPN, vaddr_q[LARGE_OFF-1:0]};
          rsp_hit_d      = 1'b0;
          rsp_spec_hit_d = 1'b0;
          miss_cnt_d     = sat_inc(miss_cnt_q);
          fill_en        = !FLUSH;
          fill_large     = 1'b1;
          fill_vpn       = {vaddr_q[VA_W-1:LARGE_OFF], {LD{1'b0}}};
          fill_ppn       = {WALK_L_PPN, {LD{1'b0}}};
        end
      end
      default: ;
    endcase
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (FLUSH) begin
      valid_d = '0;
      ptr_d   = '0;
    end else if (fill_en) begin
      valid_d[victim] = 1'b1;
      if (!has_inv) ptr_d = ptr_q + 1'b1;
    end
  end

  // Outputs decoded from state so walk requests drop as soon as reset asserts.
  always_comb begin
    REQ_READY    = (state_q == S_IDLE);
    RSP_VALID    = (state_q == S_RESP);
    RSP_PADDR    = rsp_paddr_q;
    RSP_HIT      = rsp_hit_q;
    RSP_SPEC_HIT = rsp_spec_hit_q;
    WALK_S_RQST  = (state_q == S_WALK_S);
    WALK_L_RQST  = (state_q == S_WALK_L);
    WALK_S_VPN   = WALK_S_RQST ? vaddr_q[VA_W-1:SMALL_OFF] : '0;
    WALK_L_VPN   = WALK_L_RQST ? vaddr_q[VA_W-1:LARGE_OFF] : '0;
    HIT_CNT      = hit_cnt_q;
    MISS_CNT     = miss_cnt_q;
  end

endmodule

// File: tb/tb_spec_tlb_gen2.sv
// Scoreboard bench for spec_tlb_gen2 with directed vectors.
module tb_spec_tlb_gen2;

  logic       clk = 1'b0;
  logic       rst;
  logic       REQ_VALID, REQ_READY, REQ_SPEC;
  logic [8:0] REQ_VADDR;
  logic       RSP_VALID, RSP_HIT, RSP_SPEC_HIT;
  logic [8:0] RSP_PADDR;
  logic       FLUSH;
  logic       WALK_S_RQST, WALK_S_DONE;
  logic [5:0] WALK_S_VPN, WALK_S_PPN;
  logic       WALK_L_RQST, WALK_L_DONE;
  logic [3:0] WALK_L_VPN, WALK_L_PPN;
  logic [15:0] HIT_CNT, MISS_CNT;

  spec_tlb_gen2 dut (
    .clk(clk), .rst(rst),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SPEC(REQ_SPEC), .REQ_VADDR(REQ_VADDR),
    .RSP_VALID(RSP_VALID), .RSP_PADDR(RSP_PADDR), .RSP_HIT(RSP_HIT), .RSP_SPEC_HIT(RSP_SPEC_HIT),
    .FLUSH(FLUSH),
    .WALK_S_RQST(WALK_S_RQST), .WALK_S_VPN(WALK_S_VPN), .WALK_S_DONE(WALK_S_DONE), .WALK_S_PPN(WALK_S_PPN),
    .WALK_L_RQST(WALK_L_RQST), .WALK_L_VPN(WALK_L_VPN), .WALK_L_DONE(WALK_L_DONE), .WALK_L_PPN(WALK_L_PPN),
    .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] paddr;
    logic       hit;
    logic       spec_hit;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_hc   = 0;
  int   exp_mc   = 0;
  bit   cnt_pend = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops one expectation per response, then checks counters a cycle later.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (cnt_pend) begin
      chk("hit_cnt", HIT_CNT, exp_hc);
      chk("miss_cnt", MISS_CNT, exp_mc);
      cnt_pend = 0;
    end
    if (!rst && RSP_VALID) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = q.pop_front();
        chk("rsp_paddr", RSP_PADDR, e.paddr);
        chk("rsp_hit", RSP_HIT, e.hit);
        chk("rsp_spec_hit", RSP_SPEC_HIT, e.spec_hit);
        chk("rsp_cycle", cyc, e.cyc);
        if (e.hit) exp_hc++;
        else       exp_mc++;
        cnt_pend = 1;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && (q.size() != 0 || cnt_pend); i++) tick();
    chk("drain", int'(q.size() == 0 && !cnt_pend), 1);
  endtask

  task automatic issue(input logic spec, input logic [8:0] va, output int acc);
    int w = 0;
    while (!REQ_READY && w < 20) begin
      tick();
      w++;
    end
    chk("req_ready", REQ_READY, 1);
    REQ_VALID = 1'b1;
    REQ_SPEC  = spec;
    REQ_VADDR = va;
    tick();
    acc       = cyc;
    REQ_VALID = 1'b0;
  endtask

  task automatic req_hit(input logic spec, input logic [8:0] va, input logic sh, input logic [8:0] pa);
    int acc;
    int walks = 0;
    exp_t e;
    issue(spec, va, acc);
    e.paddr = pa; e.hit = 1'b1; e.spec_hit = sh; e.cyc = acc + 1;
    q.push_back(e);
    for (int i = 0; i < 3; i++) begin
      if (WALK_S_RQST || WALK_L_RQST) walks++;
      tick();
    end
    chk("no_walk_on_hit", walks, 0);
    wait_drain();
  endtask

  // flush_mode: FLUSH held from one cycle before DONE through the DONE cycle.
  task automatic req_miss(input logic spec, input logic [8:0] va, input logic [5:0] vpn,
                          input logic [5:0] ppn, input logic [8:0] pa, input bit flush_mode);
    int   acc;
    int   w = 0;
    exp_t e;
    issue(spec, va, acc);
    while (!(spec ? WALK_L_RQST : WALK_S_RQST) && w < 20) begin
      tick();
      w++;
    end
    chk("walk_rqst", spec ? WALK_L_RQST : WALK_S_RQST, 1);
    chk("walk_vpn", spec ? WALK_L_VPN : WALK_S_VPN, vpn);
    chk("other_rqst", spec ? WALK_S_RQST : WALK_L_RQST, 0);
    // The other walker's DONE must be ignored.
    if (spec) WALK_S_DONE = 1'b1;
    else      WALK_L_DONE = 1'b1;
    WALK_S_PPN = 6'h3F;
    WALK_L_PPN = 4'hF;
    FLUSH      = flush_mode;
    tick();
    WALK_S_DONE = 1'b0;
    WALK_L_DONE = 1'b0;
    chk("rqst_held", spec ? WALK_L_RQST : WALK_S_RQST, 1);
    chk("vpn_held", spec ? WALK_L_VPN : WALK_S_VPN, vpn);
    if (spec) begin
      WALK_L_DONE = 1'b1;
      WALK_L_PPN  = ppn[3:0];
    end else begin
      WALK_S_DONE = 1'b1;
      WALK_S_PPN  = ppn;
    end
    e.paddr = pa; e.hit = 1'b0; e.spec_hit = 1'b0; e.cyc = cyc + 1;
    q.push_back(e);
    tick();
    WALK_S_DONE = 1'b0;
    WALK_L_DONE = 1'b0;
    FLUSH       = 1'b0;
    chk("rqst_dropped", spec ? WALK_L_RQST : WALK_S_RQST, 0);
    wait_drain();
  endtask

  initial begin
    int acc;
    int w;
    int spurious;
    rst = 1'b1;
    REQ_VALID = 1'b0; REQ_SPEC = 1'b0; REQ_VADDR = '0; FLUSH = 1'b0;
    WALK_S_DONE = 1'b0; WALK_S_PPN = '0; WALK_L_DONE = 1'b0; WALK_L_PPN = '0;
    repeat (2) tick();
    chk("rst_req_ready", REQ_READY, 1);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_rsp_paddr", RSP_PADDR, 0);
    chk("rst_rsp_hit", {RSP_HIT, RSP_SPEC_HIT}, 0);
    chk("rst_rqst", {WALK_S_RQST, WALK_L_RQST}, 0);
    chk("rst_vpn", {WALK_S_VPN, WALK_L_VPN}, 0);
    chk("rst_cnt", {HIT_CNT, MISS_CNT}, 0);
    rst = 1'b0;
    tick();

    // Basic small miss then hit; large fill and hit from a non-spec request.
    req_miss(1'b0, 9'h1AB, 6'h35, 6'h12, 9'h093, 1'b0);
    req_hit (1'b0, 9'h1AB, 1'b0, 9'h093);
    req_miss(1'b1, 9'h0E7, 6'h07, 6'h09, 9'h127, 1'b0);
    req_hit (1'b0, 9'h0F0, 1'b1, 9'h130);
    // Small entry 0x35 must not satisfy a spec request.
    req_miss(1'b1, 9'h1AB, 6'h0D, 6'h03, 9'h06B, 1'b0);

    // Flush in IDLE, then fill past capacity to exercise round-robin.
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    req_miss(1'b0, 9'h000, 6'h00, 6'h20, 9'h100, 1'b0);
    req_miss(1'b0, 9'h008, 6'h01, 6'h21, 9'h108, 1'b0);
    req_miss(1'b0, 9'h010, 6'h02, 6'h22, 9'h110, 1'b0);
    req_miss(1'b0, 9'h018, 6'h03, 6'h23, 9'h118, 1'b0);
    req_miss(1'b0, 9'h020, 6'h04, 6'h24, 9'h120, 1'b0);
    req_hit (1'b0, 9'h023, 1'b0, 9'h123);
    req_miss(1'b0, 9'h000, 6'h00, 6'h30, 9'h180, 1'b0);
    req_hit (1'b0, 9'h005, 1'b0, 9'h185);
    req_miss(1'b0, 9'h008, 6'h01, 6'h31, 9'h188, 1'b0);
    req_hit (1'b0, 9'h01F, 1'b0, 9'h11F);

    // Flush spanning the fill: response delivered, nothing retained.
    req_miss(1'b0, 9'h1AB, 6'h35, 6'h12, 9'h093, 1'b1);
    req_miss(1'b0, 9'h1AB, 6'h35, 6'h12, 9'h093, 1'b0);
    req_miss(1'b0, 9'h023, 6'h04, 6'h24, 9'h123, 1'b0);

    // Reset in the middle of a large walk.
    issue(1'b1, 9'h0E7, acc);
    w = 0;
    while (!WALK_L_RQST && w < 20) begin
      tick();
      w++;
    end
    chk("abort_walk_rqst", WALK_L_RQST, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_rqst_drop", WALK_L_RQST, 0);
    chk("abort_ready", REQ_READY, 1);
    chk("abort_rsp_valid", RSP_VALID, 0);
    chk("abort_cnt", {HIT_CNT, MISS_CNT}, 0);
    exp_hc = 0;
    exp_mc = 0;
    tick();
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      if (RSP_VALID) spurious++;
      tick();
    end
    chk("abort_no_rsp", spurious, 0);
    chk("abort_no_pending", q.size(), 0);
    req_miss(1'b1, 9'h0E7, 6'h07, 6'h09, 9'h127, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
